regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard and optional write-to-read bypass. It serves the pipelined RV32I core: the decode/issue stage reads operands and marks destinations busy, and writeback ports commit results. x0 is hardwired to zero. x2 (sp) resets to a configurable stack top.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH entries, x0 included.
DATA_WIDTH, 32, register data width.
NUM_RD, 2, number of read ports (1..4).
NUM_WR, 1, number of write ports (1..2).
BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.
SP_INIT, 32'h00003ffc, reset value of x2.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rstn_i  in  1  reset, asynchronous, active-low.
ra_i  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
data_o  out  NUM_RD*DATA_WIDTH  read data per port (combinational).
rdy_o  out  NUM_RD  operand ready per port (combinational).
we_i  in  NUM_WR  write enable per port.
rw_i  in  NUM_WR*ADDR_WIDTH  write addresses.
wdata_i  in  NUM_WR*DATA_WIDTH  write data.
alloc_i  in  1  mark alloc_addr_i busy (issue of an instruction with a destination).
alloc_addr_i  in  ADDR_WIDTH  destination register being allocated.
flush_i  in  1  clear all busy bits (pipeline flush).
busy_o  out  2**ADDR_WIDTH  scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset (rstn_i low, async): all registers 0 except x2 = SP_INIT; all busy bits 0. Writes, alloc, flush and bypass are ignored while reset is asserted. Outputs during reset: data_o = reset contents (0, or SP_INIT for x2); rdy_o all 1; busy_o all 0.
- Read: zero latency. Address 0 gives data 0 and rdy 1 regardless of any other input. Otherwise data = stored value; rdy = ~busy[addr].
- Bypass (BYPASS=1): if any write port has we=1 and a matching nonzero address, data_o = that port's wdata_i and rdy = 1 in the same cycle. With BYPASS=0, read returns the old value until the next cycle, and rdy follows busy.
- Write: on a rising edge, if we[j] and rw[j] != 0, then reg[rw[j]] <= wdata[j]. Writes to x0 are dropped. If two ports write the same address, the higher-index port wins, for both storage and bypass.
- Scoreboard, per register r != 0, evaluated at each edge, first match applies:
  1. flush_i = 1: busy[r] <= 0. flush overrides alloc and write in the same cycle.
  2. alloc_i = 1 and alloc_addr_i == r: busy[r] <= 1. alloc beats a same-cycle write to r, because the write belongs to an older producer.
  3. Any enabled write to r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- alloc of x0 is ignored. busy[0] is constant 0.
- A read in the same cycle as an alloc of the same address still sees the old busy value. The new busy value is visible from the next cycle.
- Reset mid-operation: all state returns immediately to reset values. Pending busy bits are lost.
- No multi-cycle operations and no handshake back-pressure. The caller must stall issue while a needed rdy is 0.

Test Plan:
- Reset release, read x2 and x5 on ports 0 and 1 -> data 32'h00003ffc and 0, rdy both 1, busy_o = 0.
- Write x5 = 32'hdeadbeef (we=1), read x5 in the same cycle and the next cycle -> BYPASS=1: beef in both cycles; BYPASS=0: 0, then beef.
- Write x0 = 32'h1234, then read x0 -> data 0, rdy 1; busy_o[0] = 0 after alloc_addr_i = 0.
- alloc x7, then read x7 the next cycle -> rdy 0, busy_o[7] = 1. Write x7 = 5 -> same-cycle bypass rdy 1 with data 5; busy_o[7] = 0 the next cycle.
- In one cycle, alloc x9 and write x9 = 3 -> reg holds 3 and busy_o[9] = 1. Then flush_i together with alloc x9 -> busy_o = 0.
- NUM_WR=2, both ports write x4 (11 and 22) -> stored and bypassed value 22. Assert rstn_i low mid-cycle -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard and optional write-to-read bypass.
// Latency: reads are combinational (zero cycles); writes and scoreboard updates land on the next rising edge.
// Backpressure: none; the issue stage must stall itself while a needed operand's rdy_o is low.
module regfile_mp #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_RD     = 2,
  parameter int                    NUM_WR     = 1,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h00003ffc
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] data_o,
  output logic [NUM_RD-1:0]            rdy_o,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] rw_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
  input  logic                         alloc_i,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr_i,
  input  logic                         flush_i,
  output logic [2**ADDR_WIDTH-1:0]     busy_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  // Architectural state. Entry 0 is held at zero by reset and never written.
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  // Unpacked views of the flattened port buses.
  logic [ADDR_WIDTH-1:0] w_wa   [NUM_WR];
  logic [DATA_WIDTH-1:0] w_wd   [NUM_WR];
  logic [ADDR_WIDTH-1:0] w_ra   [NUM_RD];

  // Per-register write resolution and next scoreboard value.
  logic [DEPTH-1:0]      w_wr_hit;
  logic [DATA_WIDTH-1:0] w_wr_dat [DEPTH];
  logic [DEPTH-1:0]      w_busy_nxt;

  // A write to x0 is meaningless; such ports are treated as idle everywhere.
  logic [NUM_WR-1:0]     w_wr_act;

  genvar g;
  generate
    for (g = 0; g < NUM_WR; g++) begin : g_wr
      assign w_wa[g]     = rw_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wd[g]     = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_wr_act[g] = we_i[g] && (w_wa[g] != '0);
    end
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      assign w_ra[g] = ra_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Fold the write ports onto registers; iterating upward lets the higher port win a collision.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      w_wr_dat[r] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (w_wr_act[j]) begin
        w_wr_hit[w_wa[j]] = 1'b1;
        w_wr_dat[w_wa[j]] = w_wd[j];
      end
    end
  end

  // Register storage: reset loads zeros and the stack top into x2, otherwise commit writes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_regs[r] <= (r == 2) ? SP_INIT : '0;
      end
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_dat[r];
        end
      end
    end
  end

  // Scoreboard next state: writeback retires, then a new allocation re-arms (the write is from an older producer).
  always_comb begin
    w_busy_nxt = r_busy & ~w_wr_hit;
    if (alloc_i && (alloc_addr_i != '0)) begin
      w_busy_nxt[alloc_addr_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register: flush wipes every pending destination, overriding alloc and write.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_busy <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_o = r_busy;

  // Operand read: stored value and scoreboard, overridden by a same-cycle write when bypass is built,
  // and by x0 last. Bypass is suppressed while reset is held so outputs show reset contents.
  always_comb begin
    data_o = '0;
    rdy_o  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ra[k]];
      rdy_o[k]                           = ~r_busy[w_ra[k]];
      if ((BYPASS != 0) && rstn_i) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_act[j] && (w_wa[j] == w_ra[k])) begin
            data_o[k*DATA_WIDTH +: DATA_WIDTH] = w_wd[j];
            rdy_o[k]                           = 1'b1;
          end
        end
      end
      if (w_ra[k] == '0) begin
        data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        rdy_o[k]                           = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass with two write ports, no bypass with one write port)
// share one stimulus stream and are compared against an array-based reference model.
// Inputs change on the falling edge; outputs are sampled shortly after, well away from the rising edge.
module tb_regfile_mp;

  logic        clk;
  logic        rstn;
  logic [9:0]  ra;
  logic [1:0]  we;
  logic [9:0]  rw;
  logic [63:0] wdata;
  logic        alloc;
  logic [4:0]  alloc_addr;
  logic        flush;

  logic [63:0] data_a, data_b;
  logic [1:0]  rdy_a, rdy_b;
  logic [31:0] busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: [0] models the bypass/2-write instance, [1] the no-bypass/1-write instance.
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];

  regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .ra_i(ra), .data_o(data_a), .rdy_o(rdy_a),
    .we_i(we), .rw_i(rw), .wdata_i(wdata), .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .flush_i(flush), .busy_o(busy_a)
  );

  regfile_mp #(.NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .ra_i(ra), .data_o(data_b), .rdy_o(rdy_b),
    .we_i(we[0:0]), .rw_i(rw[4:0]), .wdata_i(wdata[31:0]), .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .flush_i(flush), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[i][r]  = (r == 2) ? 32'h00003ffc : 32'h0;
        m_busy[i][r] = 1'b0;
      end
    end
  endtask

  // Expected {rdy, data} for a read of address a on instance i with the current inputs.
  function automatic logic [32:0] exp_read(input int i, input logic [4:0] a);
    logic [31:0] d;
    logic        rd;
    if (a == 5'd0) return {1'b1, 32'h0};
    d  = m_reg[i][a];
    rd = !m_busy[i][a];
    if (i == 0 && rstn) begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && rw[j*5 +: 5] == a) begin
          d  = wdata[j*32 +: 32];
          rd = 1'b1;
        end
      end
    end
    return {rd, d};
  endfunction

  task automatic check_model();
    logic [32:0] e;
    logic [31:0] ev;
    logic [31:0] gd;
    logic        gr;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        e  = exp_read(i, ra[k*5 +: 5]);
        gd = (i == 0) ? data_a[k*32 +: 32] : data_b[k*32 +: 32];
        gr = (i == 0) ? rdy_a[k] : rdy_b[k];
        chk($sformatf("data i%0d p%0d a%0d", i, k, ra[k*5 +: 5]), {32'h0, gd}, {32'h0, e[31:0]});
        chk($sformatf("rdy i%0d p%0d a%0d", i, k, ra[k*5 +: 5]), {63'h0, gr}, {63'h0, e[32]});
      end
      ev = '0;
      for (int r = 1; r < 32; r++) ev[r] = m_busy[i][r];
      chk($sformatf("busy i%0d", i), {32'h0, (i == 0) ? busy_a : busy_b}, {32'h0, ev});
    end
  endtask

  // Clock-edge behaviour of the reference: later write ports overwrite earlier ones;
  // scoreboard applies flush, else retire writes and then re-arm the allocated destination.
  task automatic model_update();
    int         nw;
    logic [4:0] a;
    for (int i = 0; i < 2; i++) begin
      nw = (i == 0) ? 2 : 1;
      for (int j = 0; j < nw; j++) begin
        a = rw[j*5 +: 5];
        if (we[j] && a != 5'd0) m_reg[i][a] = wdata[j*32 +: 32];
      end
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
      end else begin
        for (int j = 0; j < nw; j++) begin
          a = rw[j*5 +: 5];
          if (we[j] && a != 5'd0) m_busy[i][a] = 1'b0;
        end
        if (alloc && alloc_addr != 5'd0) m_busy[i][alloc_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    check_model();
    @(posedge clk);
    if (rstn) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 2'b00; rw = '0; wdata = '0; alloc = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rstn = 1'b0;
    ra   = '0;
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset contents: x2 holds the stack top, x5 is zero.
    ra = {5'd5, 5'd2};
    #1;
    chk("rst_x2", {32'h0, data_a[31:0]}, 64'h3ffc);
    chk("rst_x5", {32'h0, data_a[63:32]}, 64'h0);
    chk("rst_rdy", {62'h0, rdy_a}, 64'h3);
    chk("rst_busy", {32'h0, busy_a}, 64'h0);
    tick();

    // Write x5 and read it in the same cycle and the next.
    we = 2'b01; rw = {5'd0, 5'd5}; wdata = {32'h0, 32'hdeadbeef}; ra = {5'd0, 5'd5};
    #1;
    chk("byp_same", {32'h0, data_a[31:0]}, 64'hdeadbeef);
    chk("nobyp_same", {32'h0, data_b[31:0]}, 64'h0);
    tick();
    idle();
    #1;
    chk("byp_next", {32'h0, data_a[31:0]}, 64'hdeadbeef);
    chk("nobyp_next", {32'h0, data_b[31:0]}, 64'hdeadbeef);
    tick();

    // x0 ignores writes and allocation.
    we = 2'b01; rw = {5'd0, 5'd0}; wdata = {32'h0, 32'h1234}; ra = {5'd0, 5'd0};
    #1;
    chk("x0_wr_data", {32'h0, data_a[31:0]}, 64'h0);
    chk("x0_wr_rdy", {63'h0, rdy_a[0]}, 64'h1);
    tick();
    idle(); alloc = 1'b1; alloc_addr = 5'd0;
    #1;
    tick();
    idle();
    #1;
    chk("x0_busy", {63'h0, busy_a[0]}, 64'h0);
    chk("x0_data", {32'h0, data_a[31:0]}, 64'h0);
    tick();

    // Allocate x7, see it busy, then retire it by write with bypass.
    alloc = 1'b1; alloc_addr = 5'd7; ra = {5'd0, 5'd7};
    #1;
    chk("alloc_same_rdy", {63'h0, rdy_a[0]}, 64'h1);
    tick();
    idle();
    #1;
    chk("alloc_rdy", {63'h0, rdy_a[0]}, 64'h0);
    chk("alloc_busy7", {63'h0, busy_a[7]}, 64'h1);
    tick();
    we = 2'b01; rw = {5'd0, 5'd7}; wdata = {32'h0, 32'd5};
    #1;
    chk("wb_byp_rdy", {63'h0, rdy_a[0]}, 64'h1);
    chk("wb_byp_data", {32'h0, data_a[31:0]}, 64'd5);
    chk("wb_nobyp_rdy", {63'h0, rdy_b[0]}, 64'h0);
    tick();
    idle();
    #1;
    chk("wb_busy7", {63'h0, busy_a[7]}, 64'h0);
    tick();

    // Alloc and write x9 together: alloc wins. Then flush beats alloc.
    alloc = 1'b1; alloc_addr = 5'd9; we = 2'b01; rw = {5'd0, 5'd9}; wdata = {32'h0, 32'd3};
    #1;
    tick();
    idle(); ra = {5'd0, 5'd9};
    #1;
    chk("aw_data9", {32'h0, data_a[31:0]}, 64'd3);
    chk("aw_busy9", {63'h0, busy_a[9]}, 64'h1);
    tick();
    flush = 1'b1; alloc = 1'b1; alloc_addr = 5'd9;
    #1;
    tick();
    idle();
    #1;
    chk("flush_busy_a", {32'h0, busy_a}, 64'h0);
    chk("flush_busy_b", {32'h0, busy_b}, 64'h0);
    tick();

    // Both write ports hit x4: the higher port wins.
    we = 2'b11; rw = {5'd4, 5'd4}; wdata = {32'd22, 32'd11}; ra = {5'd0, 5'd4};
    #1;
    chk("dual_byp", {32'h0, data_a[31:0]}, 64'd22);
    tick();
    idle();
    #1;
    chk("dual_store", {32'h0, data_a[31:0]}, 64'd22);
    chk("single_store", {32'h0, data_b[31:0]}, 64'd11);
    tick();

    // Asynchronous reset in the middle of an active cycle.
    we = 2'b01; rw = {5'd0, 5'd5}; wdata = {32'h0, 32'haaaa}; ra = {5'd5, 5'd2};
    alloc = 1'b1; alloc_addr = 5'd3;
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_x2", {32'h0, data_a[31:0]}, 64'h3ffc);
    chk("arst_x5", {32'h0, data_a[63:32]}, 64'h0);
    chk("arst_rdy", {62'h0, rdy_a}, 64'h3);
    chk("arst_busy", {32'h0, busy_a}, 64'h0);
    tick();
    rstn = 1'b1;
    idle(); ra = {5'd5, 5'd4};
    #1;
    chk("arst_x4", {32'h0, data_a[31:0]}, 64'h0);
    tick();

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 1500; n++) begin
      ra         = {rnd_addr(), rnd_addr()};
      we         = 2'($urandom);
      rw         = {rnd_addr(), rnd_addr()};
      wdata      = {$urandom, $urandom};
      alloc      = ($urandom_range(0, 2) == 0);
      alloc_addr = rnd_addr();
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      if ($urandom_range(0, 49) == 0) begin
        rstn = 1'b0;
        model_reset();
        #1;
      end
      tick();
      rstn = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
